// File: rtl/alu_arbiter_if.sv
// Bundle shared by the two ALU requesters, the external ALU and the
// response consumer. The arbiter connects through the slave modport; the
// environment around it uses the master modport.
interface alu_arbiter_if #(
  parameter int DATA_W = 8
);
  // Requester 0 (execute stage)
  logic              r0_valid;
  logic              r0_ready;
  logic [3:0]        r0_op;
  logic [1:0]        r0_ra;
  logic [DATA_W-1:0] r0_a;
  logic [DATA_W-1:0] r0_b;
  // Requester 1 (secondary issue port)
  logic              r1_valid;
  logic              r1_ready;
  logic [3:0]        r1_op;
  logic [1:0]        r1_ra;
  logic [DATA_W-1:0] r1_a;
  logic [DATA_W-1:0] r1_b;
  // Shared combinational ALU
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [3:0]        alu_op;
  logic [1:0]        alu_ra;
  logic [DATA_W-1:0] alu_out;
  logic              alu_c;
  logic              alu_z;
  logic              alu_n;
  logic              alu_v;
  // Response channel and condition codes
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_src;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic [3:0]        ccr;

  modport slave (
    input  r0_valid, r0_op, r0_ra, r0_a, r0_b,
    input  r1_valid, r1_op, r1_ra, r1_a, r1_b,
    output r0_ready, r1_ready,
    output alu_a, alu_b, alu_op, alu_ra,
    input  alu_out, alu_c, alu_z, alu_n, alu_v,
    output rsp_valid, rsp_src, rsp_data, rsp_err, ccr,
    input  rsp_ready
  );

  modport master (
    output r0_valid, r0_op, r0_ra, r0_a, r0_b,
    output r1_valid, r1_op, r1_ra, r1_a, r1_b,
    input  r0_ready, r1_ready,
    input  alu_a, alu_b, alu_op, alu_ra,
    output alu_out, alu_c, alu_z, alu_n, alu_v,
    input  rsp_valid, rsp_src, rsp_data, rsp_err, ccr,
    output rsp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One operation is in flight at a time: IDLE (grant) -> EXEC (capture) ->
// RESP (hold until consumed). Owns the condition-code register {C,Z,N,V},
// updating only the flags each opcode defines.
module alu_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_ROT = 4'b0110;
  localparam logic [3:0] OP_UNA = 4'b1000;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state;
  logic              rr_ptr;
  logic              grant0;
  logic              grant1;
  logic [DATA_W-1:0] alu_a_p0;
  logic [DATA_W-1:0] alu_b_p0;
  logic [3:0]        alu_op_p0;
  logic [1:0]        alu_ra_p0;
  logic              rsp_src_p0;
  logic [DATA_W-1:0] rsp_data_p1;
  logic              rsp_err_p1;
  logic [3:0]        ccr_p1;
  logic              vld_p1;

  function automatic logic op_legal(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_ROT) || (op == OP_UNA);
  endfunction

  // Flag merge: flg and cur are both {C,Z,N,V}; unlisted flags are held.
  function automatic logic [3:0] ccr_next(input logic [3:0] op, input logic [1:0] ra,
                                          input logic [3:0] cur, input logic [3:0] flg);
    logic [3:0] nxt;
    nxt = cur;
    case (op)
      OP_ADD, OP_SUB: nxt = flg;
      OP_AND, OP_OR:  nxt[2:1] = flg[2:1];
      OP_ROT: begin
        case (ra)
          2'd2:    nxt[3] = 1'b1;
          2'd3:    nxt[3] = 1'b0;
          default: nxt[3] = flg[3];
        endcase
      end
      OP_UNA: begin
        if (ra[1]) nxt = flg;
        else       nxt[2:1] = flg[2:1];
      end
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

  // Grant decode: only in IDLE; on contention rr_ptr names the winner.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (bus.r0_valid && bus.r1_valid) begin
        grant0 = ~rr_ptr;
        grant1 = rr_ptr;
      end else begin
        grant0 = bus.r0_valid;
        grant1 = bus.r1_valid;
      end
    end
  end

  assign bus.r0_ready  = grant0;
  assign bus.r1_ready  = grant1;
  assign bus.alu_a     = alu_a_p0;
  assign bus.alu_b     = alu_b_p0;
  assign bus.alu_op    = alu_op_p0;
  assign bus.alu_ra    = alu_ra_p0;
  assign bus.rsp_valid = vld_p1;
  assign bus.rsp_src   = rsp_src_p0;
  assign bus.rsp_data  = rsp_data_p1;
  assign bus.rsp_err   = rsp_err_p1;
  assign bus.ccr       = ccr_p1;

  // Operation sequencer: latch operands, capture result and flags, hold response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= 1'b0;
      alu_a_p0    <= '0;
      alu_b_p0    <= '0;
      alu_op_p0   <= '0;
      alu_ra_p0   <= '0;
      rsp_src_p0  <= 1'b0;
      rsp_data_p1 <= '0;
      rsp_err_p1  <= 1'b0;
      ccr_p1      <= '0;
      vld_p1      <= 1'b0;
    end else begin
      case (state)
        // p0: operands of the granted requester enter the ALU
        IDLE: begin
          if (grant0 || grant1) begin
            alu_a_p0   <= grant1 ? bus.r1_a  : bus.r0_a;
            alu_b_p0   <= grant1 ? bus.r1_b  : bus.r0_b;
            alu_op_p0  <= grant1 ? bus.r1_op : bus.r0_op;
            alu_ra_p0  <= grant1 ? bus.r1_ra : bus.r0_ra;
            rsp_src_p0 <= grant1;
            rr_ptr     <= ~grant1;
            state      <= EXEC;
          end
        end
        // p1: ALU result and flags captured using the latched opcode
        EXEC: begin
          if (op_legal(alu_op_p0)) begin
            rsp_data_p1 <= bus.alu_out;
            rsp_err_p1  <= 1'b0;
            ccr_p1      <= ccr_next(alu_op_p0, alu_ra_p0, ccr_p1,
                                    {bus.alu_c, bus.alu_z, bus.alu_n, bus.alu_v});
          end else begin
            rsp_data_p1 <= '0;
            rsp_err_p1  <= 1'b1;
          end
          vld_p1 <= 1'b1;
          state  <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            vld_p1 <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
